// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and
// EX operand forwarding selects.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_FREEZE = 2'b01,
    ST_FLUSH  = 2'b10
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// Forwarding select for one EX source operand. The youngest producer wins:
// EX/MEM is preferred over MEM/WB, and register 0 is never forwarded.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] ex_src,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_write_reg,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_write_reg,
  output logic [1:0] fwd_sel
);

  // Pick the most recent in-flight writer of ex_src, else the register file.
  always_comb begin
    fwd_sel = FWD_RF;
    if (mem_reg_write && (mem_write_reg != 5'd0) && (mem_write_reg == ex_src)) begin
      fwd_sel = FWD_MEM;
    end else if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == ex_src)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Sequencing controller for the 5-stage pipeline. Each cycle at most one
// event applies, in priority order: taken branch (RUN only), data-memory
// freeze, load-use stall. Also keeps saturating stall/flush counters and a
// sticky flag for freezes that last too long.
//
// Data-memory handshake: the MEM stage asserts mem_access for as long as its
// access is outstanding; the access completes in the cycle dmem_ready=1.
// Every cycle with mem_access=1 and dmem_ready=0 is a freeze cycle.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int FREEZE_MAX = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_write_reg,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_write_reg,
  input  logic             mem_access,
  input  logic             mem_branch_taken,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_write_reg,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic             pipe_hold,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err_timeout
);

  localparam int                FC_W   = $clog2(FREEZE_MAX + 1);
  localparam logic [FC_W-1:0]   FC_MAX = FC_W'(FREEZE_MAX);
  localparam logic [CNT_W-1:0]  CNT_SAT = '1;

  state_t          state_q;
  state_t          state_d;
  logic [FC_W-1:0] frz_cnt;
  logic [FC_W-1:0] frz_inc;
  logic            frz_hit;
  logic            id_match;
  logic            branch_ev;
  logic            freeze_ev;
  logic            loaduse_ev;

  assign state_o = state_q;

  // Event decode. The branch is ignored outside RUN: after a flush the MEM
  // stage holds a bubble, and during a freeze MEM holds a memory op.
  assign id_match   = (id_uses_rs && (id_rs == ex_write_reg)) ||
                      (id_uses_rt && (id_rt == ex_write_reg));
  assign branch_ev  = (state_q == ST_RUN) && mem_branch_taken;
  assign freeze_ev  = !branch_ev && mem_access && !dmem_ready;
  assign loaduse_ev = !branch_ev && !freeze_ev && ex_mem_read && ex_reg_write &&
                      (ex_write_reg != 5'd0) && id_match;

  // Freeze-length counter saturates at FREEZE_MAX so it cannot wrap.
  assign frz_inc = (frz_cnt == FC_MAX) ? frz_cnt : frz_cnt + 1'b1;
  assign frz_hit = (state_q == ST_FREEZE) && (frz_inc == FC_MAX);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a load-use stall never leaves RUN, everything else
  // returns to RUN unless a freeze is (still) in progress.
  always_comb begin
    state_d = ST_RUN;
    unique case (state_q)
      ST_RUN: begin
        if (branch_ev) begin
          state_d = ST_FLUSH;
        end else if (freeze_ev) begin
          state_d = ST_FREEZE;
        end
      end
      ST_FREEZE, ST_FLUSH: begin
        if (freeze_ev) begin
          state_d = ST_FREEZE;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Pipeline control outputs for the event chosen this cycle.
  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_mem_flush   = 1'b0;
    pipe_hold      = 1'b0;
    if (branch_ev) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (freeze_ev) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      pipe_hold      = 1'b1;
    end else if (loaduse_ev) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_bubble   = 1'b1;
    end
  end

  // Performance counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst || cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (loaduse_ev && (stall_cnt != CNT_SAT)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (branch_ev && (flush_cnt != CNT_SAT)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  // Freeze length tracking and the sticky timeout flag. The freeze itself
  // keeps going; the flag only records that it overstayed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frz_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if ((state_q == ST_FREEZE) && (state_d == ST_FREEZE)) begin
        frz_cnt <= frz_inc;
      end else begin
        frz_cnt <= '0;
      end
      if (cnt_clr) begin
        err_timeout <= 1'b0;
      end else if (frz_hit) begin
        err_timeout <= 1'b1;
      end
    end
  end

  forward_unit u_fwd_a (
    .ex_src        (ex_rs),
    .mem_reg_write (mem_reg_write),
    .mem_write_reg (mem_write_reg),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .fwd_sel       (fwd_a_sel)
  );

  forward_unit u_fwd_b (
    .ex_src        (ex_rt),
    .mem_reg_write (mem_reg_write),
    .mem_write_reg (mem_write_reg),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .fwd_sel       (fwd_b_sel)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the pipeline rules.
module tb_hazard_controller;

  localparam int CNT_W      = 2;
  localparam int FREEZE_MAX = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
  logic             id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write;
  logic             mem_reg_write, mem_access, mem_branch_taken, wb_reg_write;
  logic             dmem_ready, cnt_clr;
  logic             pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble;
  logic             ex_mem_flush, pipe_hold, err_timeout;
  logic [1:0]       fwd_a_sel, fwd_b_sel, state_o;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_controller #(.CNT_W(CNT_W), .FREEZE_MAX(FREEZE_MAX)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_write_reg(ex_write_reg), .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
    .mem_access(mem_access), .mem_branch_taken(mem_branch_taken),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_flush(ex_mem_flush), .pipe_hold(pipe_hold),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .state_o(state_o),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err_timeout(err_timeout)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int hold_seen = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 normal, 1 waiting on memory, 2 guard cycle after a taken branch
  int m_mode, m_stall, m_flush, m_run;
  bit m_err;
  bit m_known = 0;

  function automatic int fwd_model(int src, bit mrw, int mwr, bit wrw, int wwr);
    if (mrw && mwr != 0 && mwr == src) return 2;
    if (wrw && wwr != 0 && wwr == src) return 1;
    return 0;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cyc();
    bit br, frz, lu, hit;
    int nm;
    @(negedge clk);
    br  = (m_mode == 0) && mem_branch_taken;
    frz = !br && mem_access && !dmem_ready;
    hit = (id_uses_rs && id_rs == ex_write_reg) || (id_uses_rt && id_rt == ex_write_reg);
    lu  = !br && !frz && ex_mem_read && ex_reg_write && ex_write_reg != 0 && hit;
    if (pipe_hold === 1'b1) hold_seen++;
    if (m_known) begin
      exp_q.push_back(32'(!(frz || lu)));
      exp_q.push_back(32'(!(frz || lu)));
      exp_q.push_back(32'(br));
      exp_q.push_back(32'(br || lu));
      exp_q.push_back(32'(br));
      exp_q.push_back(32'(frz));
      exp_q.push_back(32'(fwd_model(ex_rs, mem_reg_write, mem_write_reg, wb_reg_write, wb_write_reg)));
      exp_q.push_back(32'(fwd_model(ex_rt, mem_reg_write, mem_write_reg, wb_reg_write, wb_write_reg)));
      exp_q.push_back(32'(m_mode));
      exp_q.push_back(32'(m_stall));
      exp_q.push_back(32'(m_flush));
      exp_q.push_back(32'(m_err));
      chk("pc_write_en",    32'(pc_write_en),    exp_q.pop_front());
      chk("if_id_write_en", 32'(if_id_write_en), exp_q.pop_front());
      chk("if_id_flush",    32'(if_id_flush),    exp_q.pop_front());
      chk("id_ex_bubble",   32'(id_ex_bubble),   exp_q.pop_front());
      chk("ex_mem_flush",   32'(ex_mem_flush),   exp_q.pop_front());
      chk("pipe_hold",      32'(pipe_hold),      exp_q.pop_front());
      chk("fwd_a_sel",      32'(fwd_a_sel),      exp_q.pop_front());
      chk("fwd_b_sel",      32'(fwd_b_sel),      exp_q.pop_front());
      chk("state_o",        32'(state_o),        exp_q.pop_front());
      chk("stall_cnt",      32'(stall_cnt),      exp_q.pop_front());
      chk("flush_cnt",      32'(flush_cnt),      exp_q.pop_front());
      chk("err_timeout",    32'(err_timeout),    exp_q.pop_front());
    end
    @(posedge clk);
    if (!rst) begin
      m_mode = 0; m_stall = 0; m_flush = 0; m_run = 0; m_err = 0;
      m_known = 1;
    end else begin
      nm = br ? 2 : (frz ? 1 : 0);
      if (m_mode == 1) begin
        // Length of the current freeze, counted in FREEZE-state cycles.
        if (m_run + 1 >= FREEZE_MAX && !cnt_clr) m_err = 1;
        m_run = (nm == 1) ? m_run + 1 : 0;
      end else begin
        m_run = 0;
      end
      if (cnt_clr) begin
        m_stall = 0; m_flush = 0; m_err = 0;
      end else begin
        if (lu && m_stall < CNT_MAX) m_stall++;
        if (br && m_flush < CNT_MAX) m_flush++;
      end
      m_mode = nm;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rst = 1; cnt_clr = 0;
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_mem_read = 0; ex_reg_write = 0; ex_write_reg = 0;
    mem_reg_write = 0; mem_write_reg = 0; mem_access = 0; mem_branch_taken = 0;
    wb_reg_write = 0; wb_write_reg = 0; dmem_ready = 1;
  endtask

  task automatic set_loaduse();
    ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = 8; id_rs = 8; id_uses_rs = 1;
  endtask

  task automatic rand_inputs();
    rst = ($urandom_range(0, 63) != 0);
    cnt_clr = ($urandom_range(0, 31) == 0);
    id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
    id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
    ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
    ex_mem_read = 1'($urandom); ex_reg_write = 1'($urandom);
    ex_write_reg = 5'($urandom_range(0, 3));
    mem_reg_write = 1'($urandom); mem_write_reg = 5'($urandom_range(0, 3));
    wb_reg_write = 1'($urandom); wb_write_reg = 5'($urandom_range(0, 3));
    mem_access = ($urandom_range(0, 2) == 0);
    dmem_ready = ($urandom_range(0, 3) == 0);
    mem_branch_taken = ($urandom_range(0, 7) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle(); rst = 0;
    cyc(); cyc();
    idle();
    cyc();
    chk("rst_state", 32'(state_o), 0);
    chk("rst_pc_we", 32'(pc_write_en), 1);

    // T1 load-use: one stall cycle, then normal
    set_loaduse();
    cyc();
    ex_mem_read = 0;
    cyc();
    chk("t1_stall_cnt", 32'(stall_cnt), 1);
    chk("t1_pc_we_after", 32'(pc_write_en), 1);

    // T2 taken branch, held for a second cycle
    idle(); mem_branch_taken = 1;
    cyc();
    chk("t2_state_flush", 32'(state_o), 2);
    cyc();
    chk("t2_flush_cnt", 32'(flush_cnt), 1);
    idle();
    cyc();

    // T3 freeze: 3 wait cycles then ready
    hold_seen = 0;
    mem_access = 1; dmem_ready = 0;
    cyc(); cyc(); cyc();
    dmem_ready = 1;
    cyc();
    chk("t3_hold_cycles", 32'(hold_seen), 3);
    chk("t3_no_timeout", 32'(err_timeout), 0);
    idle();
    cyc();
    chk("t3_state_run", 32'(state_o), 0);
    // 5 wait cycles exceed FREEZE_MAX
    mem_access = 1; dmem_ready = 0;
    for (int i = 0; i < 5; i++) cyc();
    dmem_ready = 1;
    cyc();
    idle();
    cyc(); cyc();
    chk("t3_timeout_sticky", 32'(err_timeout), 1);

    // T4 priority: branch + load-use, then freeze + load-use
    idle(); set_loaduse(); mem_branch_taken = 1;
    cyc();
    chk("t4_br_stall_cnt", 32'(stall_cnt), 1);
    idle(); cyc();
    set_loaduse(); mem_access = 1; dmem_ready = 0;
    #1;
    chk("t4_frz_hold", 32'(pipe_hold), 1);
    chk("t4_frz_no_bubble", 32'(id_ex_bubble), 0);
    cyc();
    idle(); cyc();

    // T5 forwarding
    ex_rs = 5; mem_write_reg = 5; wb_write_reg = 5; mem_reg_write = 1; wb_reg_write = 1;
    cyc();
    chk("t5_fwd_mem", 32'(fwd_a_sel), 2);
    ex_rs = 0; mem_write_reg = 0; wb_write_reg = 0;
    cyc();
    chk("t5_fwd_r0", 32'(fwd_a_sel), 0);

    // T6 saturation, then reset in the middle of a freeze
    idle(); cnt_clr = 1; cyc();
    idle();
    for (int i = 0; i < 5; i++) begin
      set_loaduse(); cyc();
      ex_mem_read = 0; cyc();
    end
    chk("t6_stall_sat", 32'(stall_cnt), CNT_MAX);
    idle(); mem_access = 1; dmem_ready = 0;
    cyc(); cyc();
    rst = 0;
    cyc();
    idle();
    #1;
    chk("t6_rst_state", 32'(state_o), 0);
    chk("t6_rst_stall", 32'(stall_cnt), 0);
    chk("t6_rst_flush", 32'(flush_cnt), 0);
    cyc();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cyc();
    end

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
